// File: rtl/vec_loader.sv
// vec_loader: gathers WIDTH_VECTOR lane words of N bits from a valid/ready
// stream into one vector. It writes num_vec consecutive vectors into a
// register file, starting at base_addr. The address wraps modulo
// 2**WIDTH_ADDR.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start, abort         one-cycle load request / cancel current load
//   base_addr, num_vec   first destination address / vector count (0..2**WIDTH_ADDR)
//   s_valid, s_data      lane word stream input
//   s_ready              lane word accepted when s_valid && s_ready
//   we, addr, wdata      register-file write port (lane k at wdata[k*N +: N])
//   busy, done           not-idle flag / one-cycle completion pulse
//
// Optional feature (macro VEC_LOADER_STATUS_EN): adds output vec_cnt, which
// counts vectors written since the last accepted start.
module vec_loader #(
  parameter int WIDTH_ADDR   = 4,
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WIDTH_ADDR-1:0]       base_addr,
  input  logic [WIDTH_ADDR:0]         num_vec,
  input  logic                        s_valid,
  input  logic [N-1:0]                s_data,
  output logic                        s_ready,
  output logic                        we,
  output logic [WIDTH_ADDR-1:0]       addr,
  output logic [WIDTH_VECTOR*N-1:0]   wdata,
  output logic                        busy,
  output logic                        done
`ifdef VEC_LOADER_STATUS_EN
  ,
  output logic [WIDTH_ADDR:0]         vec_cnt
`endif
);

  localparam int LW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                      state;
  logic [LW-1:0]               lane;
  logic [WIDTH_ADDR:0]         rem;
  logic [WIDTH_ADDR-1:0]       cur_addr;
  logic [WIDTH_VECTOR*N-1:0]   lanes;
  logic [WIDTH_VECTOR*N-1:0]   lanes_nxt;
  logic                        we_q;

  // An abort seen during WRITE must cancel that cycle's strobe. The
  // registered strobe is therefore gated by abort at the output.
  assign we = we_q & ~abort;

  always_comb begin
    lanes_nxt = lanes;
    lanes_nxt[int'(lane)*N +: N] = s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lane     <= '0;
      rem      <= '0;
      cur_addr <= '0;
      lanes    <= '0;
      s_ready  <= 1'b0;
      we_q     <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            busy <= 1'b1;
            if (num_vec != '0) begin
              cur_addr <= base_addr;
              rem      <= num_vec;
              lane     <= '0;
              s_ready  <= 1'b1;
              state    <= FILL;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FILL: begin
          if (abort) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            lane    <= '0;
            state   <= IDLE;
          end else if (s_valid && s_ready) begin
            lanes <= lanes_nxt;
            if (lane == LW'(WIDTH_VECTOR - 1)) begin
              wdata   <= lanes_nxt;
              addr    <= cur_addr;
              we_q    <= 1'b1;
              s_ready <= 1'b0;
              lane    <= '0;
              state   <= WRITE;
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cur_addr <= cur_addr + 1'b1;
            rem      <= rem - 1'b1;
            if (rem == (WIDTH_ADDR+1)'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              s_ready <= 1'b1;
              lane    <= '0;
              state   <= FILL;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEC_LOADER_STATUS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      vec_cnt <= '0;
    else if (state == IDLE && start && !abort)
      vec_cnt <= '0;
    else if (we)
      vec_cnt <= vec_cnt + 1'b1;
  end
`else
  // No status counter in this build.
`endif

endmodule

// File: doc/vec_loader.md
VEC_LOADER -- requirements
Module: vec_loader

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 4, register-file address width.
REQ-002 SHALL have parameter WIDTH_VECTOR, default 8, lanes per vector.
REQ-003 SHALL have parameter N, default 32, bits per lane.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port abort  input  1  cancel the current load.
REQ-008 SHALL have port base_addr  input  WIDTH_ADDR  first destination address.
REQ-009 SHALL have port num_vec  input  WIDTH_ADDR+1  vectors to load, 0..2**WIDTH_ADDR.
REQ-010 SHALL have port s_valid  input  1  lane word valid.
REQ-011 SHALL have port s_data  input  N  lane word.
REQ-012 SHALL have port s_ready  output  1  lane word accepted when s_valid&&s_ready.
REQ-013 SHALL have port we  output  1  register-file write strobe.
REQ-014 SHALL have port addr  output  WIDTH_ADDR  register-file address.
REQ-015 SHALL have port wdata  output  WIDTH_VECTOR*N  assembled vector, lane k at bits [k*N +: N].
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-019 IDLE: s_ready=0, we=0; start with num_vec!=0 latches base_addr, num_vec, clears lane index, goes to FILL.
REQ-020 IDLE with start and num_vec==0 SHALL go directly to DONE, no write.
REQ-021 FILL: s_ready=1; each accepted word stored in lane index, index increments from 0.
REQ-022 FILL: acceptance of lane WIDTH_VECTOR-1 SHALL go to WRITE next cycle.
REQ-023 WRITE: s_ready=0, we=1 for exactly one cycle, addr=current address, wdata=all WIDTH_VECTOR lanes.
REQ-024 WRITE: address increments modulo 2**WIDTH_ADDR (wraps 2**WIDTH_ADDR-1 -> 0); remaining count decrements.
REQ-025 WRITE: remaining reaching 0 SHALL go to DONE, otherwise to FILL with lane index 0.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort in FILL or WRITE SHALL go to IDLE next cycle, suppress we that cycle, discard partial vector, no done pulse.
REQ-029 abort and start in the same IDLE cycle: abort wins, start ignored.
REQ-030 Minimum latency: last lane accepted at cycle t -> we at t+1; done at t+2 for the final vector.
REQ-031 wdata and addr SHALL hold their values outside WRITE; consumers sample only when we=1.

Reset
REQ-032 rstn low SHALL asynchronously force IDLE, lane index 0, remaining 0, and all of s_ready, we, busy, done, addr, wdata to 0.
REQ-033 rstn asserted mid-load SHALL discard the load; no we or done after release until a new start.

Configuration
REQ-034 Macro VEC_LOADER_STATUS_EN defined SHALL add output vec_cnt [WIDTH_ADDR:0] counting vectors written since last start: cleared by accepted start, +1 per we, reset 0, held after abort.
REQ-035 Without VEC_LOADER_STATUS_EN, port vec_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 base_addr=3, num_vec=2, 16 words 0x0..0xF, s_valid always high -> we at addr 3 with lane0=0x0..lane7=0x7, we at addr 4 with lane0=0x8, done 1 cycle after second we.
REQ-037 base_addr=15, num_vec=2 -> writes at addr 15 then addr 0 (wrap).
REQ-038 num_vec=0 with start -> done next cycle, we never asserted, busy high exactly 1 cycle.
REQ-039 s_valid toggling every other cycle, num_vec=1 -> same wdata as continuous feed, we 1 cycle after 8th acceptance.
REQ-040 abort after 5 accepted words -> IDLE next cycle, no we, no done; new start base_addr=0 num_vec=1 then loads correctly from lane 0.
REQ-041 rstn low during WRITE -> we=0, busy=0 immediately; with VEC_LOADER_STATUS_EN, vec_cnt=0.
